// File: rtl/led_status_seq.sv
// -----------------------------------------------------------------------------
// led_status_seq
//
// Blinks a 4-bit fault code on a single LED-request line. A code of N gives
// bursts of N on/off blinks, and a dark gap follows each burst. A free-running
// prescaler makes one timing tick every TICK_DIV clocks. Each phase lasts a
// whole number of ticks.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   code_in     in   [3:0] blink code, 0 = no fault, 1..15 = blinks per burst
//   code_load   in   one-cycle strobe that samples code_in
//   status      out  registered LED-on request (high only in ON)
//   busy        out  registered, high whenever the sequencer is not IDLE
//   code_active out  [3:0] registered code currently being blinked, 0 in IDLE
//
// Configuration macro
//   LED_STATUS_SEQ_REPEAT_EN  defined: when no new code is pending at the end
//                             of a gap, the same code repeats indefinitely.
//                             undefined (default): one burst per load, then
//                             the sequencer returns to IDLE.
// -----------------------------------------------------------------------------
module led_status_seq #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int ON_TICKS  = 20,
    parameter int OFF_TICKS = 20,
    parameter int GAP_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] code_in,
    input  logic       code_load,
    output logic       status,
    output logic       busy,
    output logic [3:0] code_active
);

    localparam int MAX_OO    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
    localparam int PH_W      = $clog2(MAX_TICKS) + 1;
    localparam int PS_W      = $clog2(TICK_DIV);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PS_W-1:0]   r_presc;
    logic [PH_W-1:0]   r_phase;
    logic [3:0]        r_blinks;
    logic [3:0]        r_code;
    logic [3:0]        r_pend;
    logic              r_pend_valid;
    logic              r_status;
    logic              r_busy;

    state_t            w_next_state;
    logic [3:0]        w_next_code;
    logic [3:0]        w_next_blinks;
    logic [3:0]        w_blinks_inc;
    logic [3:0]        w_gap_sel;
    logic              w_tick;
    logic              w_phase_end;
    logic              w_phase_clr;
    logic              w_presc_clr;
    logic              w_pend_take;

    assign w_tick = (r_presc == PS_LAST);

    // The blink counter saturates rather than wrapping. It can never pass 15
    // anyway, because the burst ends when it equals the (<=15) active code.
    assign w_blinks_inc = (r_blinks == 4'hF) ? r_blinks : r_blinks + 4'd1;

    always_comb begin
        w_phase_end = 1'b0;
        case (r_state)
            ON:      w_phase_end = w_tick && (r_phase == ON_LAST);
            OFF:     w_phase_end = w_tick && (r_phase == OFF_LAST);
            GAP:     w_phase_end = w_tick && (r_phase == GAP_LAST);
            default: w_phase_end = 1'b0;
        endcase
    end

    // Pick the code for the next burst at gap end. A load in that same cycle
    // takes precedence over anything still pending.
    always_comb begin
        w_gap_sel = 4'd0;
        if (code_load) begin
            w_gap_sel = code_in;
        end else if (r_pend_valid) begin
            w_gap_sel = r_pend;
        end else begin
`ifdef LED_STATUS_SEQ_REPEAT_EN
            w_gap_sel = r_code;
`else
            w_gap_sel = 4'd0;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_code   = r_code;
        w_next_blinks = r_blinks;
        w_phase_clr   = (r_state == IDLE);
        w_presc_clr   = 1'b0;
        w_pend_take   = 1'b0;

        case (r_state)
            IDLE: begin
                if (code_load && (code_in != 4'd0)) begin
                    w_next_state  = ON;
                    w_next_code   = code_in;
                    w_next_blinks = 4'd0;
                    // Re-align the tick grid so the first ON is full length.
                    w_presc_clr   = 1'b1;
                end
            end
            ON: begin
                if (w_phase_end) begin
                    w_phase_clr   = 1'b1;
                    w_next_blinks = w_blinks_inc;
                    w_next_state  = (w_blinks_inc == r_code) ? GAP : OFF;
                end
            end
            OFF: begin
                if (w_phase_end) begin
                    w_phase_clr  = 1'b1;
                    w_next_state = ON;
                end
            end
            GAP: begin
                if (w_phase_end) begin
                    w_phase_clr   = 1'b1;
                    w_next_blinks = 4'd0;
                    w_pend_take   = 1'b1;
                    w_next_code   = w_gap_sel;
                    w_next_state  = (w_gap_sel == 4'd0) ? IDLE : ON;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_code  = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state is assigned with non-blocking (<=) so that every
    // register samples the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_code   <= 4'd0;
            r_blinks <= 4'd0;
            r_status <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_code   <= w_next_code;
            r_blinks <= w_next_blinks;
            r_status <= (w_next_state == ON);
            r_busy   <= (w_next_state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_presc_clr) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_phase_clr) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // Loads that arrive while a burst is running are parked here. The last
    // one wins, and it is consumed only at gap end, so a burst is never cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= 4'd0;
            r_pend_valid <= 1'b0;
        end else if (w_pend_take) begin
            r_pend_valid <= 1'b0;
        end else if (code_load && (r_state != IDLE)) begin
            r_pend       <= code_in;
            r_pend_valid <= 1'b1;
        end
    end

    assign status      = r_status;
    assign busy        = r_busy;
    assign code_active = r_code;

endmodule
